// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit framer:
//   - state_t      : framer FSM states
//   - PAR_*        : cfg_parity encodings
//   - *_DATA_BITS_DEF : default bounds for the data field width
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5,
      ST_STOP2  = 3'd6
   } state_t;

   localparam logic [1:0] PAR_NONE  = 2'b00;
   localparam logic [1:0] PAR_EVEN  = 2'b01;
   localparam logic [1:0] PAR_ODD   = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   localparam int MIN_DATA_BITS_DEF = 5;
   localparam int MAX_DATA_BITS_DEF = 9;

endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc
//   Combinational parity generator over the low 'len' bits of 'data'.
//   Ports:
//     data   in  WIDTH  data word (bits at or above len are ignored)
//     len    in  4      number of valid data bits
//     mode   in  2      parity mode (PAR_NONE/EVEN/ODD/SPACE)
//     parity out 1      parity bit (0 for NONE and SPACE)
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int WIDTH = MAX_DATA_BITS_DEF
) (
   input  logic [WIDTH-1:0] data,
   input  logic [3:0]       len,
   input  logic [1:0]       mode,
   output logic             parity
);

   logic [WIDTH-1:0] masked;
   logic             xor_all;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign masked[gi] = data[gi] & (len > 4'(gi));
      end
   endgenerate

   assign xor_all = ^masked;

   always_comb begin
      parity = 1'b0;
      case (mode)
         PAR_EVEN: parity = xor_all;
         PAR_ODD:  parity = ~xor_all;
         default:  parity = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//   UART transmit framer/serializer. Accepts one word per valid/ready
//   handshake, latches the frame configuration, then shifts out start,
//   data (LSB first), optional parity and one or two stop bits, advancing
//   one bit per baud_tick.
//   Ports:
//     clk          in   1              system clock
//     rst_n        in   1              synchronous reset, active-low
//     baud_tick    in   1              bit-boundary strobe
//     s_valid      in   1              source has a word
//     s_ready      out  1              framer can accept a word (IDLE only)
//     s_data       in   MAX_DATA_BITS  data word
//     cfg_data_len in   4              data bits per frame (clamped MIN..MAX)
//     cfg_parity   in   2              parity mode
//     cfg_stop2    in   1              second stop bit enable
//     tx           out  1              serial line, idle high
//     busy         out  1              frame in progress
//     frame_done   out  1              pulse when the last stop bit ends
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = MAX_DATA_BITS_DEF,
   parameter int MIN_DATA_BITS = MIN_DATA_BITS_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     baud_tick,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [MAX_DATA_BITS-1:0] s_data,
   input  logic [3:0]               cfg_data_len,
   input  logic [1:0]               cfg_parity,
   input  logic                     cfg_stop2,
   output logic                     tx,
   output logic                     busy,
   output logic                     frame_done
);

   state_t                   state_reg;
   logic                     tx_reg;
   logic                     ready_reg;
   logic                     busy_reg;
   logic                     done_reg;
   logic [3:0]               cnt_reg;
   logic [MAX_DATA_BITS-1:0] shift_reg;
   logic [MAX_DATA_BITS-1:0] data_reg;
   logic [3:0]               len_reg;
   logic [1:0]               par_reg;
   logic                     stop2_reg;

   logic [3:0]               len_clamped;
   logic                     parity_bit;

   always_comb begin
      len_clamped = cfg_data_len;
      if (cfg_data_len < 4'(MIN_DATA_BITS)) begin
         len_clamped = 4'(MIN_DATA_BITS);
      end else if (cfg_data_len > 4'(MAX_DATA_BITS)) begin
         len_clamped = 4'(MAX_DATA_BITS);
      end
   end

   // Parity is taken from an unshifted copy of the word so the shift
   // register can be consumed freely during DATA.
   uart_parity_calc #(
      .WIDTH (MAX_DATA_BITS)
   ) u_parity (
      .data   (data_reg),
      .len    (len_reg),
      .mode   (par_reg),
      .parity (parity_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         tx_reg    <= 1'b1;
         ready_reg <= 1'b1;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         len_reg   <= 4'(MIN_DATA_BITS);
         par_reg   <= PAR_NONE;
         stop2_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               // A tick coincident with the transfer is deliberately ignored:
               // ARM always waits for a fresh tick.
               if (s_valid && ready_reg) begin
                  state_reg <= ST_ARM;
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  shift_reg <= s_data;
                  data_reg  <= s_data;
                  len_reg   <= len_clamped;
                  par_reg   <= cfg_parity;
                  stop2_reg <= cfg_stop2;
                  cnt_reg   <= '0;
               end
            end
            ST_ARM: begin
               if (baud_tick) begin
                  state_reg <= ST_START;
                  tx_reg    <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_tick) begin
                  state_reg <= ST_DATA;
                  cnt_reg   <= '0;
                  tx_reg    <= shift_reg[0];
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  shift_reg <= shift_reg >> 1;
                  cnt_reg   <= cnt_reg + 4'd1;
                  if (cnt_reg == len_reg - 4'd1) begin
                     if (par_reg != PAR_NONE) begin
                        state_reg <= ST_PARITY;
                        tx_reg    <= parity_bit;
                     end else begin
                        state_reg <= ST_STOP;
                        tx_reg    <= 1'b1;
                     end
                  end else begin
                     tx_reg <= shift_reg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (baud_tick) begin
                  state_reg <= ST_STOP;
                  tx_reg    <= 1'b1;
               end
            end
            ST_STOP, ST_STOP2: begin
               if (baud_tick) begin
                  tx_reg <= 1'b1;
                  if (state_reg == ST_STOP && stop2_reg) begin
                     state_reg <= ST_STOP2;
                  end else begin
                     state_reg <= ST_IDLE;
                     busy_reg  <= 1'b0;
                     ready_reg <= 1'b1;
                     done_reg  <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign tx         = tx_reg;
   assign s_ready    = ready_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//   Self-checking bench for uart_tx_framer: hand-written frame table,
//   randomized frames against a string-based frame model, back-to-back
//   handshake and mid-frame reset sequences.
module tb_uart_tx_framer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud_tick = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [8:0] s_data = '0;
   logic [3:0] cfg_data_len = 4'd8;
   logic [1:0] cfg_parity = 2'b00;
   logic       cfg_stop2 = 1'b0;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int tick_div = 1;

   typedef struct {
      logic [8:0] data;
      logic [3:0] len;
      logic [1:0] par;
      logic       stop2;
      int         div;
      string      exp;
   } vec_t;

   vec_t vecs[9];

   uart_tx_framer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .baud_tick    (baud_tick),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .cfg_data_len (cfg_data_len),
      .cfg_parity   (cfg_parity),
      .cfg_stop2    (cfg_stop2),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
      $fatal(1, "watchdog");
   end

   function automatic string bstr(input logic b);
      if (b === 1'b1) return "1";
      if (b === 1'b0) return "0";
      return "x";
   endfunction

   // Expected line sequence (start .. last stop) from the framing rules.
   function automatic string model(input logic [8:0] d, input logic [3:0] l,
                                   input logic [1:0] p, input logic s2);
      int    n;
      int    ones;
      string s;
      n = (l < 4'd5) ? 5 : ((l > 4'd9) ? 9 : int'(l));
      s = "0";
      ones = 0;
      for (int i = 0; i < n; i++) begin
         s = {s, bstr(d[i])};
         ones += int'(d[i]);
      end
      if (p == 2'b01) s = {s, bstr(1'((ones % 2) == 1))};
      else if (p == 2'b10) s = {s, bstr(1'((ones % 2) == 0))};
      else if (p == 2'b11) s = {s, "0"};
      s = {s, "1"};
      if (s2) s = {s, "1"};
      return s;
   endfunction

   task automatic check(input string name, input bit ok, input string act, input string req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %s, required %s", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      baud_tick = (tick_div <= 1) ? 1'b1 : 1'((cyc % tick_div) == 0);
   endtask

   task automatic set_vec(input int i, input logic [8:0] d, input logic [3:0] l,
                          input logic [1:0] p, input logic s2, input int dv, input string e);
      vecs[i].data  = d;
      vecs[i].len   = l;
      vecs[i].par   = p;
      vecs[i].stop2 = s2;
      vecs[i].div   = dv;
      vecs[i].exp   = e;
   endtask

   // Waits for s_ready, presents the word for one edge, optionally drops
   // s_valid and scrambles config to prove the framer latched it.
   task automatic send(input string name, input logic [8:0] d, input logic [3:0] l,
                       input logic [1:0] p, input logic s2, input bit scramble);
      int w;
      w = 0;
      while (s_ready !== 1'b1 && w < 100) begin
         cycle();
         w++;
      end
      check({name, "_ready"}, s_ready === 1'b1, bstr(s_ready), "1");
      s_data = d;
      cfg_data_len = l;
      cfg_parity = p;
      cfg_stop2 = s2;
      s_valid = 1'b1;
      cycle();
      if (scramble) begin
         s_valid = 1'b0;
         s_data = 9'($urandom);
         cfg_data_len = 4'($urandom);
         cfg_parity = 2'($urandom);
         cfg_stop2 = 1'($urandom);
      end
      check({name, "_accept"}, busy === 1'b1 && s_ready === 1'b0,
            $sformatf("busy=%b ready=%b", busy, s_ready), "busy=1 ready=0");
   endtask

   // Records tx in every tick cycle while busy (first entry is ARM) until
   // frame_done; the returned string drops the ARM entry.
   task automatic capture(output string bits, output int ncyc, output bit done_ok,
                          output int tx_viol, output int rdy_viol);
      string raw;
      logic  pt;
      logic  ptx;
      raw = "";
      ncyc = 0;
      done_ok = 1'b0;
      tx_viol = 0;
      rdy_viol = 0;
      for (int k = 0; k < 400; k++) begin
         if (baud_tick === 1'b1 && busy === 1'b1) raw = {raw, bstr(tx)};
         pt = baud_tick;
         ptx = tx;
         cycle();
         ncyc++;
         if (tx !== ptx && pt !== 1'b1) tx_viol++;
         if (frame_done === 1'b1) begin
            done_ok = 1'b1;
            break;
         end
         if (s_ready !== 1'b0) rdy_viol++;
      end
      bits = (raw.len() > 1) ? raw.substr(1, raw.len() - 1) : "";
   endtask

   task automatic run_frame(input string name, input logic [8:0] d, input logic [3:0] l,
                            input logic [1:0] p, input logic s2, input int dv, input string exp);
      string bits;
      int    ncyc;
      bit    done_ok;
      int    tx_viol;
      int    rdy_viol;
      tick_div = dv;
      send(name, d, l, p, s2, 1'b1);
      capture(bits, ncyc, done_ok, tx_viol, rdy_viol);
      check({name, "_bits"}, bits == exp, bits, exp);
      check({name, "_done"}, done_ok, $sformatf("%0d", done_ok), "1");
      check({name, "_tx_after_tick"}, tx_viol == 0, $sformatf("%0d", tx_viol), "0");
      check({name, "_ready_low"}, rdy_viol == 0, $sformatf("%0d", rdy_viol), "0");
      check({name, "_idle_at_done"}, busy === 1'b0 && s_ready === 1'b1 && tx === 1'b1,
            $sformatf("busy=%b ready=%b tx=%b", busy, s_ready, tx), "busy=0 ready=1 tx=1");
      if (dv == 1)
         check({name, "_cycles"}, ncyc == exp.len() + 1,
               $sformatf("%0d", ncyc), $sformatf("%0d", exp.len() + 1));
      cycle();
      check({name, "_done_pulse"}, frame_done === 1'b0, bstr(frame_done), "0");
   endtask

   initial begin
      string bits;
      string expa;
      string expb;
      int    ncyc;
      bit    done_ok;
      int    tx_viol;
      int    rdy_viol;
      int    t;
      int    k;
      int    extra;

      set_vec(0, 9'h0A5, 4'd8,  2'b00, 1'b0, 4, "0101001011");
      set_vec(1, 9'h041, 4'd7,  2'b01, 1'b1, 3, "01000001011");
      set_vec(2, 9'h043, 4'd7,  2'b01, 1'b1, 1, "01100001111");
      set_vec(3, 9'h1FF, 4'd9,  2'b10, 1'b0, 2, "011111111101");
      set_vec(4, 9'h1FF, 4'd9,  2'b11, 1'b0, 1, "011111111101");
      set_vec(5, 9'h1FF, 4'd9,  2'b01, 1'b0, 4, "011111111111");
      set_vec(6, 9'h01F, 4'd3,  2'b00, 1'b0, 1, "0111111");
      set_vec(7, 9'h155, 4'd12, 2'b00, 1'b0, 2, "01010101011");
      set_vec(8, 9'h1E3, 4'd5,  2'b10, 1'b1, 3, "011000111");

      // Reset state
      rst_n = 1'b0;
      repeat (3) cycle();
      check("rst_tx", tx === 1'b1, bstr(tx), "1");
      check("rst_ready", s_ready === 1'b1, bstr(s_ready), "1");
      check("rst_busy", busy === 1'b0, bstr(busy), "0");
      check("rst_done", frame_done === 1'b0, bstr(frame_done), "0");
      rst_n = 1'b1;
      cycle();

      // Table-driven frames
      for (int i = 0; i < 9; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].len, vecs[i].par,
                   vecs[i].stop2, vecs[i].div, vecs[i].exp);
         $display("vec%0d data=%03h len=%0d par=%0d stop2=%0d div=%0d exp=%s",
                  i, vecs[i].data, vecs[i].len, vecs[i].par, vecs[i].stop2,
                  vecs[i].div, vecs[i].exp);
      end

      // Back-to-back: s_valid held, config changed mid-frame
      tick_div = 1;
      expa = model(9'h035, 4'd6, 2'b01, 1'b0);
      expb = model(9'h0AA, 4'd8, 2'b10, 1'b1);
      send("b2b_a", 9'h035, 4'd6, 2'b01, 1'b0, 1'b0);
      s_data = 9'h0AA;
      cfg_data_len = 4'd8;
      cfg_parity = 2'b10;
      cfg_stop2 = 1'b1;
      capture(bits, ncyc, done_ok, tx_viol, rdy_viol);
      check("b2b_a_bits", bits == expa, bits, expa);
      check("b2b_a_done", done_ok, $sformatf("%0d", done_ok), "1");
      check("b2b_a_no_accept", rdy_viol == 0, $sformatf("%0d", rdy_viol), "0");
      cycle();
      check("b2b_b_immediate", busy === 1'b1 && s_ready === 1'b0,
            $sformatf("busy=%b ready=%b", busy, s_ready), "busy=1 ready=0");
      s_valid = 1'b0;
      capture(bits, ncyc, done_ok, tx_viol, rdy_viol);
      check("b2b_b_bits", bits == expb, bits, expb);
      check("b2b_b_cycles", ncyc == expb.len() + 1,
            $sformatf("%0d", ncyc), $sformatf("%0d", expb.len() + 1));
      $display("b2b frames a=%s b=%s", expa, expb);

      // Reset during DATA bit 3
      tick_div = 2;
      send("rstmid", 9'h000, 4'd8, 2'b00, 1'b0, 1'b1);
      t = 0;
      k = 0;
      while (t < 5 && k < 200) begin
         if (baud_tick === 1'b1 && busy === 1'b1) t++;
         cycle();
         k++;
      end
      check("rstmid_reached_bit3", t == 5 && tx === 1'b0 && busy === 1'b1,
            $sformatf("ticks=%0d tx=%b busy=%b", t, tx, busy), "ticks=5 tx=0 busy=1");
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("rstmid_idle", tx === 1'b1 && busy === 1'b0 && s_ready === 1'b1 && frame_done === 1'b0,
            $sformatf("tx=%b busy=%b ready=%b done=%b", tx, busy, s_ready, frame_done),
            "tx=1 busy=0 ready=1 done=0");
      extra = 0;
      repeat (30) begin
         cycle();
         if (frame_done !== 1'b0) extra++;
      end
      check("rstmid_no_done", extra == 0, $sformatf("%0d", extra), "0");
      $display("reset mid-frame sequence done");
      run_frame("after_rst", 9'h05A, 4'd8, 2'b00, 1'b0, 2, "0010110101");

      // Randomized frames against the model
      for (int r = 0; r < 40; r++) begin
         logic [8:0] d;
         logic [3:0] l;
         logic [1:0] p;
         logic       s2;
         int         dv;
         d  = 9'($urandom);
         l  = 4'($urandom_range(0, 15));
         p  = 2'($urandom);
         s2 = 1'($urandom);
         dv = int'($urandom_range(1, 4));
         run_frame($sformatf("rnd%0d", r), d, l, p, s2, dv, model(d, l, p, s2));
         $display("rnd%0d data=%03h len=%0d par=%0d stop2=%0d div=%0d exp=%s",
                  r, d, l, p, s2, dv, model(d, l, p, s2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
